// File: rtl/byte_capture_fifo_if.sv
// Byte capture FIFO bundle: producer handshake, consumer handshake and status.
// The master side drives the stream and clears overflow; the slave side is the FIFO.
interface byte_capture_fifo_if #(
    parameter int DEPTH = 16
);
    logic [7:0]              in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [7:0]              out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic                    clr_ovf;

    modport master (
        output in_data, in_valid, out_ready, clr_ovf,
        input  in_ready, out_data, out_valid, count, overflow
    );

    modport slave (
        input  in_data, in_valid, out_ready, clr_ovf,
        output in_ready, out_data, out_valid, count, overflow
    );
endinterface

// File: rtl/byte_capture_fifo.sv
// Captures a registered byte stream into a FWFT FIFO, optionally storing only value changes.
// Latency: a written byte appears on out_data one cycle after the accepting edge.
// Backpressure: in_ready drops when full (state-derived only); pushes while full are dropped and flagged.
module byte_capture_fifo #(
    parameter int DEPTH       = 16,
    parameter bit CHANGE_ONLY = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    byte_capture_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic [7:0]    last_byte;
    logic          last_vld;

    logic in_ready;
    logic out_valid;
    logic keep;
    logic accept;
    logic pop;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);

    // An equal byte is suppressed silently; the first byte after reset always passes.
    assign keep   = CHANGE_ONLY ? (!last_vld || (bus.in_data != last_byte)) : 1'b1;
    assign accept = bus.in_valid && in_ready && keep;
    assign pop    = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            last_byte <= '0;
            last_vld  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr    <= wr_ptr + AW'(1);
                last_byte <= bus.in_data;
                last_vld  <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A fresh overflow event takes priority over a clear in the same cycle.
            if (bus.in_valid && !in_ready) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end
endmodule
